// File: rtl/readout_fifo_arbiter.sv
// Round-robin / priority arbiter that drains several FWFT source FIFOs into one
// 32-bit sink, granting one source at a time in bursts of at most MAX_BURST words.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no grant held; picks a winner among eligible sources (no pop)
// ST_XFER | grant held on last_q; pops while the source has data and sink has room
module readout_fifo_arbiter #(
   parameter int NUM_SRC       = 4,
   parameter int MAX_BURST     = 16,
   parameter int HIGH_PRIO_SRC = 0
) (
   input  logic                    BUS_CLK,
   input  logic                    BUS_RST,
   input  logic [NUM_SRC-1:0]      SRC_EMPTY,
   input  logic [32*NUM_SRC-1:0]   SRC_DATA,
   output logic [NUM_SRC-1:0]      SRC_READ,
   input  logic [NUM_SRC-1:0]      SRC_ENABLE,
   input  logic                    PRIO_ENABLE,
   input  logic                    OUT_FULL,
   output logic                    OUT_WRITE,
   output logic [31:0]             OUT_DATA,
   output logic [NUM_SRC-1:0]      GRANT,
   output logic [31:0]             WORD_COUNT,
   output logic                    IDLE
);

   localparam int IW = $clog2(NUM_SRC);

   typedef enum logic {ST_IDLE, ST_XFER} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        last_q, last_d;
   logic [NUM_SRC-1:0]   grant_q, grant_d;
   logic [7:0]           burst_q, burst_d;
   logic                 out_write_q, out_write_d;
   logic [31:0]          out_data_q, out_data_d;
   logic [31:0]          word_count_q, word_count_d;

   logic [NUM_SRC-1:0]   eligible;
   logic [IW-1:0]        winner;
   logic [IW-1:0]        rr_idx;
   logic                 found;
   logic                 pop;

   assign eligible = SRC_ENABLE & ~SRC_EMPTY;

   // Round-robin scan starts one past the last grant; priority override applied last.
   always_comb begin
      winner = last_q;
      rr_idx = '0;
      found  = 1'b0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         rr_idx = IW'((int'(last_q) + k) % NUM_SRC);
         if (!found && eligible[rr_idx]) begin
            winner = rr_idx;
            found  = 1'b1;
         end
      end
      if (PRIO_ENABLE && eligible[HIGH_PRIO_SRC]) begin
         winner = IW'(HIGH_PRIO_SRC);
      end
   end

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      grant_d      = grant_q;
      burst_d      = burst_q;
      out_write_d  = 1'b0;
      out_data_d   = out_data_q;
      word_count_d = word_count_q;
      SRC_READ     = '0;
      pop          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               state_d = ST_XFER;
               last_d  = winner;
               grant_d = {{(NUM_SRC-1){1'b0}}, 1'b1} << winner;
               burst_d = '0;
            end
         end
         ST_XFER: begin
            pop              = eligible[last_q] & ~OUT_FULL & ~BUS_RST;
            SRC_READ[last_q] = pop;
            if (pop) begin
               out_write_d  = 1'b1;
               out_data_d   = SRC_DATA[32*last_q +: 32];
               burst_d      = burst_q + 8'd1;
               word_count_d = word_count_q + 32'd1;
            end
            // Empty/disabled source ends the burst even while the sink is full.
            if ((pop && ({1'b0, burst_q} + 9'd1 == 9'(MAX_BURST))) || !eligible[last_q]) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         state_q      <= ST_IDLE;
         last_q       <= IW'(NUM_SRC-1);
         grant_q      <= '0;
         burst_q      <= '0;
         out_write_q  <= 1'b0;
         out_data_q   <= '0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         grant_q      <= grant_d;
         burst_q      <= burst_d;
         out_write_q  <= out_write_d;
         out_data_q   <= out_data_d;
         word_count_q <= word_count_d;
      end
   end

   assign GRANT      = grant_q;
   assign OUT_WRITE  = out_write_q;
   assign OUT_DATA   = out_data_q;
   assign WORD_COUNT = word_count_q;
   assign IDLE       = (state_q == ST_IDLE);

endmodule

// File: tb/tb_readout_fifo_arbiter.sv
// Bench for readout_fifo_arbiter: queue-based source FIFOs, a grant-policy model
// and a write scoreboard drained by an independent monitor.
module tb_readout_fifo_arbiter;

   localparam int N  = 4;
   localparam int MB = 4;
   localparam int HP = 2;

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    src_empty, src_read, src_enable, grant;
   logic [32*N-1:0] src_data;
   logic            prio, out_full, out_write, idle;
   logic [31:0]     out_data, word_count;

   logic            n_rst, n_full, n_prio;
   logic [N-1:0]    n_en;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int tb_words = 0;

   logic [31:0]  fq [N][$];
   exp_t         sb [$];
   logic [N-1:0] glog [$];
   logic [N-1:0] prev_g;

   int           m_grant, m_last, m_pops;
   logic         p_rst, p_pop, p_prio;
   logic [N-1:0] p_elig;

   readout_fifo_arbiter #(.NUM_SRC(N), .MAX_BURST(MB), .HIGH_PRIO_SRC(HP)) dut (
      .BUS_CLK    (clk),
      .BUS_RST    (rst),
      .SRC_EMPTY  (src_empty),
      .SRC_DATA   (src_data),
      .SRC_READ   (src_read),
      .SRC_ENABLE (src_enable),
      .PRIO_ENABLE(prio),
      .OUT_FULL   (out_full),
      .OUT_WRITE  (out_write),
      .OUT_DATA   (out_data),
      .GRANT      (grant),
      .WORD_COUNT (word_count),
      .IDLE       (idle)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] oh(input int g);
      logic [31:0] r;
      r = '0;
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   function automatic int pick(input logic [N-1:0] el, input logic pr, input int last);
      if (pr && el[HP]) return HP;
      for (int k = 1; k <= N; k++)
         if (el[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < N; i++)
         if (fq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Drive one cycle's inputs just after the edge, check the model at the falling edge.
   task automatic step();
      logic [N-1:0] el, exp_rd;
      exp_t         e;
      @(posedge clk);
      #1;
      rst        = n_rst;
      out_full   = n_full;
      prio       = n_prio;
      src_enable = n_en;
      for (int i = 0; i < N; i++) begin
         src_empty[i] = (fq[i].size() == 0);
         src_data[32*i +: 32] = src_empty[i] ? $urandom() : fq[i][0];
      end
      @(negedge clk);
      if (p_rst) begin
         m_grant = -1;
         m_last  = N - 1;
         m_pops  = 0;
      end else if (m_grant < 0) begin
         if (p_elig != '0) begin
            m_grant = pick(p_elig, p_prio, m_last);
            m_last  = m_grant;
            m_pops  = 0;
         end
      end else begin
         if (p_pop) m_pops++;
         if (m_pops == MB || !p_elig[m_grant]) m_grant = -1;
      end
      chk("grant", 32'(grant), oh(m_grant));
      chk("idle", 32'(idle), 32'(m_grant < 0));
      chk("word_count", word_count, 32'(tb_words));
      el     = src_enable & ~src_empty;
      exp_rd = '0;
      if (!rst && m_grant >= 0 && el[m_grant] && !out_full) exp_rd[m_grant] = 1'b1;
      chk("src_read", 32'(src_read), 32'(exp_rd));
      for (int i = 0; i < N; i++) begin
         if (src_read[i] && fq[i].size() > 0) begin
            e.d   = fq[i].pop_front();
            e.due = cyc + 1;
            sb.push_back(e);
            tb_words++;
         end
      end
      if (rst) tb_words = 0;
      if (grant != '0 && prev_g == '0) glog.push_back(grant);
      prev_g = grant;
      p_rst  = rst;
      p_elig = el;
      p_prio = prio;
      p_pop  = (exp_rd != '0);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      n_rst = 1'b1;
      step();
      n_rst = 1'b0;
      step();
      chk("rst_out_write", 32'(out_write), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_word_count", word_count, 32'd0);
   endtask

   task automatic load(input int s, input int cnt, input logic [31:0] base);
      for (int k = 0; k < cnt; k++) fq[s].push_back(base + 32'(k));
   endtask

   always @(negedge clk) begin
      exp_t m;
      if (rst) begin
         sb.delete();
      end else if (out_write) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_write cycle %0d: got word %h expected no write", cyc, out_data);
         end else begin
            m = sb.pop_front();
            chk("out_data", out_data, m.d);
            chk("write_latency", 32'(cyc), 32'(m.due));
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         checks++;
         errors++;
         $display("FAIL missing_write cycle %0d: got no write expected word %h", cyc, sb[0].d);
         void'(sb.pop_front());
      end
   end

   initial begin
      n_rst = 1'b1; n_full = 1'b0; n_prio = 1'b0; n_en = '1;
      out_full = 1'b0; prio = 1'b0; src_enable = '1; src_empty = '1; src_data = '0;
      p_rst = 1'b1; p_pop = 1'b0; p_prio = 1'b0; p_elig = '0;
      m_grant = -1; m_last = N - 1; m_pops = 0; prev_g = '0;

      // single source, three words
      do_reset();
      load(0, 3, 32'hA000_0001);
      run(10);
      chk("t1_word_count", word_count, 32'd3);
      chk("t1_idle", 32'(idle), 32'd1);
      chk("t1_grant", 32'(grant), 32'd0);

      // two sources sharing in capped bursts
      do_reset();
      glog.delete();
      load(0, 6, 32'hB000_0000);
      load(1, 6, 32'hC000_0000);
      run(30);
      chk("t2_word_count", word_count, 32'd12);
      chk("t2_bursts", 32'(glog.size()), 32'd4);
      if (glog.size() >= 4) begin
         chk("t2_order0", 32'(glog[0]), 32'h1);
         chk("t2_order1", 32'(glog[1]), 32'h2);
         chk("t2_order2", 32'(glog[2]), 32'h1);
         chk("t2_order3", 32'(glog[3]), 32'h2);
      end

      // priority source arrives during another burst
      do_reset();
      glog.delete();
      n_prio = 1'b1;
      load(1, 8, 32'hD100_0000);
      run(3);
      load(2, 4, 32'hD200_0000);
      load(3, 4, 32'hD300_0000);
      run(40);
      n_prio = 1'b0;
      chk("t3_first", 32'(glog.size() > 1 ? glog[0] : '0), 32'h2);
      chk("t3_second", 32'(glog.size() > 1 ? glog[1] : '0), 32'h4);

      // sink full for five cycles mid-burst
      do_reset();
      load(3, 8, 32'hE300_0000);
      run(3);
      n_full = 1'b1;
      run(5);
      n_full = 1'b0;
      run(25);
      chk("t4_word_count", word_count, 32'd8);

      // enable dropped mid-burst
      do_reset();
      load(0, 8, 32'hF000_0000);
      run(3);
      n_en[0] = 1'b0;
      run(3);
      chk("t5_kept", 32'(fq[0].size()), 32'd6);
      n_en = '1;
      run(25);

      // reset mid-burst, then src0 must win
      do_reset();
      load(1, 8, 32'h7100_0000);
      run(3);
      load(0, 4, 32'h7000_0000);
      glog.delete();
      do_reset();
      run(30);
      chk("t6_first", 32'(glog.size() > 0 ? glog[0] : '0), 32'h1);

      // randomized traffic
      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            int s;
            s = $urandom_range(0, N - 1);
            repeat ($urandom_range(1, 4)) fq[s].push_back($urandom());
         end
         if ($urandom_range(0, 19) == 0) n_en = N'($urandom());
         if ($urandom_range(0, 49) == 0) n_prio = ~n_prio;
         n_full = ($urandom_range(0, 4) == 0);
         n_rst  = ($urandom_range(0, 299) == 0);
         step();
      end
      n_rst = 1'b0;
      n_full = 1'b0;
      n_en = '1;
      for (int c = 0; c < 5000 && !all_empty(); c++) step();
      run(5);
      chk("drain_done", 32'(all_empty()), 32'd1);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
